// File: rtl/timer_bus_bridge.sv
// CPU-to-timer bus bridge: latches one load/store, decodes it to one of two timer windows,
// drives the device bus and returns ready/data. Optional macro BRIDGE_IRQ_LATCH_EN makes cpu_hwint sticky.
module timer_bus_bridge #(
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
    parameter int unsigned WIN_BITS    = 4
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        bus_err,
    output logic [5:0]  cpu_hwint,
    input  logic [5:0]  int_ack,
    output logic [1:0]  dev_addr,
    output logic [31:0] dev_wdata,
    output logic        dev0_we,
    output logic        dev1_we,
    input  logic [31:0] dev0_rdata,
    input  logic [31:0] dev1_rdata,
    input  logic        dev0_irq,
    input  logic        dev1_irq,
    input  logic [3:0]  ext_irq
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } state_e;

    state_e      state_q;
    logic        is_write_q;
    logic        sel1_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        we0_q;
    logic        we1_q;
    logic [1:0]  daddr_q;
    logic [31:0] dwdata_q;
    logic [5:0]  hwint_q;
    logic [5:0]  hwint_d;

    logic        req;
    logic        hit0;
    logic        hit1;
    logic [5:0]  irq_src;

    assign req     = cpu_we | cpu_re;
    assign hit0    = (cpu_addr[31:WIN_BITS] == TIMER0_BASE[31:WIN_BITS]);
    assign hit1    = (cpu_addr[31:WIN_BITS] == TIMER1_BASE[31:WIN_BITS]);
    assign irq_src = {ext_irq, dev1_irq, dev0_irq};

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q    <= IDLE;
            is_write_q <= 1'b0;
            sel1_q     <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            we0_q      <= 1'b0;
            we1_q      <= 1'b0;
            daddr_q    <= '0;
            dwdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    if (req) begin
                        if (hit0 || hit1) begin
                            // Device bus is loaded only on a hit so it keeps its last valid word otherwise
                            daddr_q    <= cpu_addr[3:2];
                            dwdata_q   <= cpu_wdata;
                            is_write_q <= cpu_we;
                            sel1_q     <= ~hit0;
                            we0_q      <= cpu_we & hit0;
                            we1_q      <= cpu_we & ~hit0;
                            state_q    <= ACCESS;
                        end else begin
                            ready_q <= 1'b1;
                            err_q   <= 1'b1;
                            state_q <= ERR;
                        end
                    end
                end
                ACCESS: begin
                    we0_q   <= 1'b0;
                    we1_q   <= 1'b0;
                    ready_q <= 1'b1;
                    if (is_write_q) begin
                        rdata_q <= '0;
                    end else if (sel1_q) begin
                        rdata_q <= dev1_rdata;
                    end else begin
                        rdata_q <= dev0_rdata;
                    end
                    state_q <= DONE;
                end
                DONE: begin
                    ready_q <= 1'b0;
                    rdata_q <= '0;
                    state_q <= IDLE;
                end
                ERR: begin
                    ready_q <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef BRIDGE_IRQ_LATCH_EN
    // Sticky: a source high in the same cycle as its ack keeps the bit set
    always_comb begin
        hwint_d = irq_src | (hwint_q & ~int_ack);
    end

    logic unused_bits;
    assign unused_bits = ^cpu_addr[1:0];
`else
    always_comb begin
        hwint_d = irq_src;
    end

    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], int_ack};
`endif

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            hwint_q <= '0;
        end else begin
            hwint_q <= hwint_d;
        end
    end

    assign cpu_rdata = rdata_q;
    assign cpu_ready = ready_q;
    assign bus_err   = err_q;
    assign cpu_hwint = hwint_q;
    assign dev_addr  = daddr_q;
    assign dev_wdata = dwdata_q;
    assign dev0_we   = we0_q;
    assign dev1_we   = we1_q;

endmodule

// File: tb/tb_timer_bus_bridge.sv
// Self-checking bench for timer_bus_bridge: transaction-level expectation tables per cycle,
// one compare process at each falling edge, plus literal spot checks.
module tb_timer_bus_bridge;

    logic        clk;
    logic        rst;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        bus_err;
    logic [5:0]  cpu_hwint;
    logic [5:0]  int_ack;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev0_we;
    logic        dev1_we;
    logic [31:0] dev0_rdata;
    logic [31:0] dev1_rdata;
    logic        dev0_irq;
    logic        dev1_irq;
    logic [3:0]  ext_irq;

    timer_bus_bridge #(
        .TIMER0_BASE(32'h0000_7F00),
        .TIMER1_BASE(32'h0000_7F10),
        .WIN_BITS   (4)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .bus_err   (bus_err),
        .cpu_hwint (cpu_hwint),
        .int_ack   (int_ack),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev0_we   (dev0_we),
        .dev1_we   (dev1_we),
        .dev0_rdata(dev0_rdata),
        .dev1_rdata(dev1_rdata),
        .dev0_irq  (dev0_irq),
        .dev1_irq  (dev1_irq),
        .ext_irq   (ext_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Timer register files seen through the word select
    function automatic logic [31:0] dev_word(input int dev, input logic [1:0] w);
        if (dev == 0) return 32'hA000_0000 + {30'd0, w};
        if (w == 2'd1) return 32'h0000_0055;
        return 32'hB000_0000 + {30'd0, w};
    endfunction

    assign dev0_rdata = dev_word(0, dev_addr);
    assign dev1_rdata = dev_word(1, dev_addr);

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic running = 1'b0;

    logic        exp_we0  [0:1023];
    logic        exp_we1  [0:1023];
    logic        exp_rdy  [0:1023];
    logic        exp_err  [0:1023];
    logic [31:0] exp_rd   [0:1023];
    logic        exp_dchk [0:1023];
    logic [1:0]  exp_daddr[0:1023];
    logic [31:0] exp_dwd  [0:1023];
    logic [5:0]  model_hw;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            model_hw <= '0;
        end else begin
`ifdef BRIDGE_IRQ_LATCH_EN
            model_hw <= {ext_irq, dev1_irq, dev0_irq} | (model_hw & ~int_ack);
`else
            model_hw <= {ext_irq, dev1_irq, dev0_irq};
`endif
        end
    end

    always @(negedge clk) begin
        if (running && cyc < 1024) begin
            chk("dev0_we", {31'd0, dev0_we}, {31'd0, exp_we0[cyc]});
            chk("dev1_we", {31'd0, dev1_we}, {31'd0, exp_we1[cyc]});
            chk("cpu_ready", {31'd0, cpu_ready}, {31'd0, exp_rdy[cyc]});
            chk("bus_err", {31'd0, bus_err}, {31'd0, exp_err[cyc]});
            chk("cpu_hwint", {26'd0, cpu_hwint}, {26'd0, model_hw});
            if (exp_rdy[cyc]) chk("cpu_rdata", cpu_rdata, exp_rd[cyc]);
            if (exp_dchk[cyc]) begin
                chk("dev_addr", {30'd0, dev_addr}, {30'd0, exp_daddr[cyc]});
                chk("dev_wdata", dev_wdata, exp_dwd[cyc]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CPU access; fills expectation tables from the address map and timing rules
    task automatic do_access(input logic we, input logic re, input logic [31:0] addr,
                             input logic [31:0] wd, output int c);
        bit h0, h1, hit, wr;
        logic [1:0] w;
        c   = cyc;
        h0  = ((addr >> 4) == (32'h7F00 >> 4));
        h1  = ((addr >> 4) == (32'h7F10 >> 4));
        hit = h0 || h1;
        wr  = we;
        w   = addr[3:2];
        if (hit) begin
            exp_we0[c+1]   = wr && h0;
            exp_we1[c+1]   = wr && !h0;
            exp_dchk[c+1]  = 1'b1;
            exp_daddr[c+1] = w;
            exp_dwd[c+1]   = wd;
            exp_rdy[c+2]   = 1'b1;
            exp_rd[c+2]    = wr ? 32'd0 : dev_word(h0 ? 0 : 1, w);
        end else begin
            exp_rdy[c+1] = 1'b1;
            exp_err[c+1] = 1'b1;
            exp_rd[c+1]  = 32'd0;
        end
        cpu_addr  = addr;
        cpu_wdata = wd;
        cpu_we    = we;
        cpu_re    = re;
        tick();
        cpu_addr  = 32'hDEAD_BEEF;
        cpu_wdata = 32'h5A5A_5A5A;
        if (!hit) begin
            cpu_we = 1'b0;
            cpu_re = 1'b0;
        end
        tick();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
        tick();
    endtask

    int c;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            exp_we0[i] = 1'b0; exp_we1[i] = 1'b0; exp_rdy[i] = 1'b0; exp_err[i] = 1'b0;
            exp_rd[i] = '0; exp_dchk[i] = 1'b0; exp_daddr[i] = '0; exp_dwd[i] = '0;
        end
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
        int_ack = '0; dev0_irq = 1'b0; dev1_irq = 1'b0; ext_irq = '0;
        tick();
        tick();
        exp_dchk[cyc] = 1'b1;
        running = 1'b1;
        @(negedge clk);
        chk("reset_rdata", cpu_rdata, 32'd0);
        chk("reset_hwint", {26'd0, cpu_hwint}, 32'd0);
        rst = 1'b0;
        tick();

        do_access(1'b1, 1'b0, 32'h0000_7F00, 32'h9, c);
        chk("pin_store_we0", {31'd0, exp_we0[c+1]}, 32'd1);
        chk("pin_store_wd", exp_dwd[c+1], 32'h9);
        chk("pin_store_rdy", {31'd0, exp_rdy[c+2]}, 32'd1);

        do_access(1'b0, 1'b1, 32'h0000_7F14, 32'h0, c);
        chk("pin_load_rd", exp_rd[c+2], 32'h55);

        do_access(1'b0, 1'b1, 32'h0000_1000, 32'h0, c);
        chk("pin_miss_err", {31'd0, exp_err[c+1]}, 32'd1);

        do_access(1'b1, 1'b1, 32'h0000_7F18, 32'h1234, c);
        chk("pin_both_addr", {30'd0, exp_daddr[c+1]}, 32'd2);
        chk("pin_both_we1", {31'd0, exp_we1[c+1]}, 32'd1);

        do_access(1'b0, 1'b1, 32'h0000_7F0C, 32'h0, c);
        do_access(1'b1, 1'b0, 32'h0000_7F13, 32'hCAFE_0001, c);
        do_access(1'b1, 1'b0, 32'h0000_7F20, 32'h77, c);
        do_access(1'b0, 1'b1, 32'h0000_7F04, 32'h0, c);

        // Reset asserted during the ACCESS cycle
        c = cyc;
        exp_we0[c+1] = 1'b1; exp_dchk[c+1] = 1'b1; exp_daddr[c+1] = 2'd1; exp_dwd[c+1] = 32'h7;
        exp_dchk[c+2] = 1'b1;
        cpu_addr = 32'h0000_7F04; cpu_wdata = 32'h7; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, cpu_ready}, 32'd0);
        chk("rst_mid_we0", {31'd0, dev0_we}, 32'd0);
        tick();
        tick();

        // Interrupt pulse on dev0_irq
        dev0_irq = 1'b1;
        tick();
        dev0_irq = 1'b0;
        @(negedge clk);
        chk("irq_pulse", {26'd0, cpu_hwint}, 32'h1);
        tick();
        @(negedge clk);
`ifdef BRIDGE_IRQ_LATCH_EN
        chk("irq_sticky", {26'd0, cpu_hwint}, 32'h1);
`else
        chk("irq_gone", {26'd0, cpu_hwint}, 32'h0);
`endif
        tick();
        tick();
        int_ack = 6'b000001;
        tick();
        int_ack = '0;
        @(negedge clk);
        chk("irq_acked", {26'd0, cpu_hwint}, 32'h0);

        // Source and ack on the same bit in the same cycle
        ext_irq = 4'b0010;
        int_ack = 6'b001000;
        tick();
        ext_irq = '0;
        int_ack = '0;
        @(negedge clk);
        chk("irq_set_wins", {26'd0, cpu_hwint}, 32'h8);
        tick();
        dev1_irq = 1'b1;
        ext_irq  = 4'b1001;
        tick();
        dev1_irq = 1'b0;
        ext_irq  = '0;
        tick();
        int_ack = '1;
        tick();
        int_ack = '0;
        tick();
        tick();

        running = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
